// File: rtl/mano_mem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port main memory.
// Port 0 is the instruction-side miss path, port 1 the data-side miss/write-back path.
module mano_mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t              state_q,    state_d;
  logic [3:0]          lat_cnt_q,  lat_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q,   mem_rd_d;
  logic                mem_wr_q,   mem_wr_d;
  logic [DATA_W-1:0]   mem_dout_q, mem_dout_d;
  logic                r0_ack_q,   r0_ack_d;
  logic                r1_ack_q,   r1_ack_d;
  logic [DATA_W-1:0]   r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0]   r1_rdata_q, r1_rdata_d;
  logic                busy_q,     busy_d;
  logic                grant_q,    grant_d;

  logic                win;
  logic                win_wr;

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    mem_dout_d = mem_dout_q;
    r0_ack_d   = 1'b0;
    r1_ack_d   = 1'b0;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    busy_d     = busy_q;
    grant_d    = grant_q;
    // A tie goes to the port that did not own the previous access.
    win        = (r0_req && r1_req) ? ~grant_q : r1_req;
    win_wr     = win ? r1_wr : r0_wr;

    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant_d    = win;
          mem_addr_d = win ? r1_addr  : r0_addr;
          mem_dout_d = win ? r1_wdata : r0_wdata;
          mem_wr_d   = win_wr;
          mem_rd_d   = ~win_wr;
          lat_cnt_d  = LAT_INIT;
          busy_d     = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_q == 4'd0) begin
          if (mem_rd_q) begin
            if (grant_q) r1_rdata_d = mem_din;
            else         r0_rdata_d = mem_din;
          end
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          r0_ack_d = ~grant_q;
          r1_ack_d = grant_q;
          state_d  = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Reset wins over everything, including an access in flight.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= IDLE;
      lat_cnt_q  <= 4'd0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      r0_ack_q   <= r0_ack_d;
      r1_ack_q   <= r1_ack_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign mem_wr   = mem_wr_q;
  assign mem_dout = mem_dout_q;
  assign r0_ack   = r0_ack_q;
  assign r1_ack   = r1_ack_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;
  assign busy     = busy_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_mano_mem_arbiter.sv
// Bench for mano_mem_arbiter: directed table, corner sequences, and a randomized
// run checked cycle by cycle against a phase-counter reference model.
module tb_mano_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        r0_req, r0_wr, r0_ack, r1_req, r1_wr, r1_ack;
  logic [11:0] r0_addr, r1_addr, mem_addr;
  logic [15:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, mem_dout, mem_din;
  logic        mem_rd, mem_wr, busy, grant;

  logic        b_clr;
  logic        b_r0_req, b_r0_wr, b_r0_ack, b_r1_req, b_r1_wr, b_r1_ack;
  logic [11:0] b_r0_addr, b_r1_addr, b_mem_addr;
  logic [15:0] b_r0_wdata, b_r1_wdata, b_r0_rdata, b_r1_rdata, b_mem_dout, b_mem_din;
  logic        b_mem_rd, b_mem_wr, b_busy, b_grant;

  mano_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .clr(clr),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .busy(busy), .grant(grant)
  );

  mano_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .clr(b_clr),
    .r0_req(b_r0_req), .r0_wr(b_r0_wr), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
    .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
    .r1_req(b_r1_req), .r1_wr(b_r1_wr), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
    .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
    .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_dout(b_mem_dout),
    .mem_din(b_mem_din), .busy(b_busy), .grant(b_grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp_v);
    end
  endtask

  // Reference model: m_t counts cycles since the grant edge (0 = idle).
  // Cycles 1..LAT carry the strobe, cycle LAT+1 carries the ack.
  int          m_t    = 0;
  logic        m_last = 1'b1;
  logic        m_own  = 1'b0;
  logic        m_wr   = 1'b0;
  logic [11:0] m_addr = '0;
  logic [15:0] m_dout = '0, m_r0 = '0, m_r1 = '0;
  bit          model_on = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!clr) begin
        m_t = 0; m_last = 1'b1; m_addr = '0; m_dout = '0; m_r0 = '0; m_r1 = '0; m_wr = 1'b0;
        model_on = 1'b1;
      end else if (m_t == 0) begin
        if (r0_req || r1_req) begin
          m_own  = (r0_req && r1_req) ? !m_last : r1_req;
          m_last = m_own;
          m_wr   = m_own ? r1_wr : r0_wr;
          m_addr = m_own ? r1_addr : r0_addr;
          m_dout = m_own ? r1_wdata : r0_wdata;
          m_t    = 1;
        end
      end else if (m_t <= LAT) begin
        if (m_t == LAT && !m_wr) begin
          if (m_own) m_r1 = mem_din;
          else       m_r0 = mem_din;
        end
        m_t++;
      end else begin
        m_t = 0;
      end
      @(negedge clk);
      if (model_on) begin
        chk("mem_rd",   32'(mem_rd),   32'(m_t >= 1 && m_t <= LAT && !m_wr));
        chk("mem_wr",   32'(mem_wr),   32'(m_t >= 1 && m_t <= LAT && m_wr));
        chk("excl",     32'(mem_rd && mem_wr), 32'(0));
        chk("busy",     32'(busy),     32'(m_t != 0));
        chk("grant",    32'(grant),    32'(m_last));
        chk("r0_ack",   32'(r0_ack),   32'(m_t == LAT + 1 && !m_own));
        chk("r1_ack",   32'(r1_ack),   32'(m_t == LAT + 1 && m_own));
        chk("r0_rdata", 32'(r0_rdata), 32'(m_r0));
        chk("r1_rdata", 32'(r1_rdata), 32'(m_r1));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_dout", 32'(mem_dout), 32'(m_dout));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        port;
    logic        wr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic [15:0] exp_r0;
    logic [15:0] exp_r1;
  } vec_t;

  vec_t vecs[5];

  task automatic drive_port(input logic port, input logic req, input logic wr,
                            input logic [11:0] addr, input logic [15:0] wdata);
    if (port) begin r1_req = req; r1_wr = wr; r1_addr = addr; r1_wdata = wdata; end
    else      begin r0_req = req; r0_wr = wr; r0_addr = addr; r0_wdata = wdata; end
  endtask

  // Issues one access from a negedge and waits (bounded) for its ack.
  task automatic run_txn(input vec_t v, output int ack_k, output int strb_n);
    ack_k  = -1;
    strb_n = 0;
    mem_din = v.din;
    drive_port(v.port, 1'b1, v.wr, v.addr, v.wdata);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_rd || mem_wr) strb_n++;
      if (k == 1) begin
        chk("txn_addr", 32'(mem_addr), 32'(v.addr));
        chk("txn_type", 32'({mem_wr, mem_rd}), 32'(v.wr ? 2'b10 : 2'b01));
        if (v.wr) chk("txn_dout", 32'(mem_dout), 32'(v.wdata));
      end
      if ((v.port ? r1_ack : r0_ack) === 1'b1) begin
        ack_k = k;
        break;
      end
    end
    drive_port(v.port, 1'b0, v.wr, v.addr, v.wdata);
    @(negedge clk);
  endtask

  int   ak, sn, acks_seen, k1_ack, k0_ack;
  int   order[$];
  bit   cool0, cool1, b_r0_seen;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 12'h123, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 12'h0FF, 16'h1234, 16'hDEAD, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 16'h0001, 16'hBEEF, 16'h0001};
    vecs[3] = '{1'b0, 1'b1, 12'h000, 16'hFFFF, 16'h5555, 16'hBEEF, 16'h0001};
    vecs[4] = '{1'b0, 1'b0, 12'hABC, 16'h0000, 16'h7E57, 16'h7E57, 16'h0001};

    clr = 1'b0; b_clr = 1'b0;
    r0_req = 0; r0_wr = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_wr = 0; r1_addr = '0; r1_wdata = '0; mem_din = '0;
    b_r0_req = 0; b_r0_wr = 0; b_r0_addr = '0; b_r0_wdata = '0;
    b_r1_req = 0; b_r1_wr = 0; b_r1_addr = '0; b_r1_wdata = '0; b_mem_din = '0;
    repeat (2) @(negedge clk);

    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 1);
    chk("rst_strobes", 32'({mem_rd, mem_wr}), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("b_rst_state", 32'({b_busy, b_mem_rd, b_mem_wr, b_r0_ack, b_r1_ack}), 0);
    chk("b_rst_grant", 32'(b_grant), 1);
    chk("b_rst_dout", 32'(b_mem_dout), 0);
    clr = 1'b1; b_clr = 1'b1;
    @(negedge clk);

    // MEM_LAT=1 build: port 1 read of 0xFFF.
    b_r1_req = 1; b_r1_wr = 0; b_r1_addr = 12'hFFF; b_mem_din = 16'h0001;
    ak = -1; sn = 0; b_r0_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (b_mem_rd) sn++;
      if (b_mem_wr || b_r0_ack) b_r0_seen = 1;
      if (k == 1) chk("b_addr", 32'(b_mem_addr), 32'h0FFF);
      if (b_r1_ack) begin ak = k; break; end
    end
    b_r1_req = 0;
    chk("b_ack_lat", ak, 2);
    chk("b_strobes", sn, 1);
    chk("b_other", 32'(b_r0_seen), 0);
    chk("b_rdata", 32'(b_r1_rdata), 32'h0001);
    chk("b_r0_rdata", 32'(b_r0_rdata), 0);
    @(negedge clk);

    // Directed table of single accesses.
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i], ak, sn);
      chk("tbl_ack_lat", ak, LAT + 1);
      chk("tbl_strobes", sn, LAT);
      chk("tbl_r0_rdata", 32'(r0_rdata), 32'(vecs[i].exp_r0));
      chk("tbl_r1_rdata", 32'(r1_rdata), 32'(vecs[i].exp_r1));
    end

    // Reset during the second ACCESS cycle of a port 0 read.
    mem_din = 16'hBEEF;
    drive_port(1'b0, 1'b1, 1'b0, 12'h321, 16'h0);
    repeat (2) @(negedge clk);
    chk("mid_in_access", 32'(mem_rd), 1);
    clr = 1'b0;
    @(negedge clk);
    chk("mid_strobes", 32'({mem_rd, mem_wr}), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_ack", 32'(r0_ack), 0);
    chk("mid_rdata", 32'(r0_rdata), 0);
    drive_port(1'b0, 1'b0, 1'b0, 12'h321, 16'h0);
    clr = 1'b1;
    @(negedge clk);
    chk("mid_noack", 32'(r0_ack), 0);
    run_txn('{1'b0, 1'b0, 12'h321, 16'h0, 16'hCAFE, 16'hCAFE, 16'h0}, ak, sn);
    chk("post_rst_lat", ak, LAT + 1);
    chk("post_rst_rdata", 32'(r0_rdata), 32'hCAFE);

    // Round robin with both ports held after a fresh reset.
    clr = 1'b0; @(negedge clk); clr = 1'b1;
    r0_req = 1; r0_wr = 0; r0_addr = 12'h010;
    r1_req = 1; r1_wr = 0; r1_addr = 12'h020;
    cool0 = 0; cool1 = 0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      mem_din = 16'(c);
      if (r0_ack)      begin order.push_back(0); r0_req = 0; cool0 = 1; end
      else if (cool0)  cool0 = 0;
      else             r0_req = 1;
      if (r1_ack)      begin order.push_back(1); r1_req = 0; cool1 = 1; end
      else if (cool1)  cool1 = 0;
      else             r1_req = 1;
    end
    r0_req = 0; r1_req = 0;
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % 2);
    repeat (LAT + 3) @(negedge clk);

    // Port 0 drops req during ACCESS while port 1 starts requesting.
    drive_port(1'b0, 1'b1, 1'b0, 12'h444, 16'h0);
    mem_din = 16'h4444;
    k0_ack = -1; k1_ack = -1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) begin
        r0_req = 0;
        drive_port(1'b1, 1'b1, 1'b1, 12'h555, 16'h5A5A);
      end
      if (r0_ack && k0_ack < 0) k0_ack = k;
      if (r1_ack) begin k1_ack = k; break; end
    end
    r1_req = 0;
    chk("drop_r0_ack", k0_ack, LAT + 1);
    chk("drop_r1_ack", k1_ack, 2 * LAT + 3);
    chk("drop_rdata", 32'(r0_rdata), 32'h4444);
    repeat (2) @(negedge clk);

    // Randomized traffic with occasional resets.
    cool0 = 0; cool1 = 0; acks_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      clr = ($urandom_range(0, 249) != 0);
      mem_din = 16'($urandom);
      if (r0_ack || r1_ack) acks_seen++;
      if (r0_req && r0_ack)  begin r0_req = 0; cool0 = 1; end
      else if (cool0)        cool0 = 0;
      else if (!r0_req && $urandom_range(0, 3) == 0)
        drive_port(1'b0, 1'b1, 1'($urandom), 12'($urandom), 16'($urandom));
      if (r1_req && r1_ack)  begin r1_req = 0; cool1 = 1; end
      else if (cool1)        cool1 = 0;
      else if (!r1_req && $urandom_range(0, 2) == 0)
        drive_port(1'b1, 1'b1, 1'($urandom), 12'($urandom), 16'($urandom));
    end
    clr = 1'b1;
    chk("rand_activity", 32'(acks_seen > 100), 1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mano_mem_arbiter.md
Name: mano_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 4096x16 main memory.
- Port 0 serves the instruction-side cache miss path; port 1 serves the data-side cache miss and write-back path.
- Grants the memory round-robin, drives mem_addr/mem_rd/mem_wr for a fixed access latency, and returns completion to the winner with a one-cycle ack pulse.

Parameters:
ADDR_W, 12, address width, matches `addrwidth
DATA_W, 16, data width, matches `datawidth
MEM_LAT, 2, cycles mem_rd/mem_wr held per access; legal range 1..15

Ports:
clk  input  1  system clock; all logic on posedge
clr  input  1  synchronous active-low reset
r0_req  input  1  port 0 request; held high until r0_ack
r0_wr  input  1  port 0 access type; 1=write, 0=read
r0_addr  input  ADDR_W  port 0 address
r0_wdata  input  DATA_W  port 0 write data
r0_ack  output  1  port 0 completion pulse
r0_rdata  output  DATA_W  port 0 read data
r1_req, r1_wr, r1_addr, r1_wdata, r1_ack, r1_rdata  (same widths/meaning)  port 1
mem_addr  output  ADDR_W  memory address
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe
mem_dout  output  DATA_W  arbiter-to-memory write data
mem_din  input  DATA_W  memory-to-arbiter read data
busy  output  1  high in ACCESS and DONE
grant  output  1  port owning the current or last access

Behaviour:
- Reset (clr=0 at posedge): state=IDLE; mem_rd=mem_wr=0; mem_addr=0; mem_dout=0; r0_ack=r1_ack=0; r0_rdata=r1_rdata=0; busy=0; grant=1; lat_cnt=0.
- Reset has priority over every other event. A reset mid-access aborts it: strobes go low at that edge, no ack is issued, and rdata keeps its reset value.
- States: IDLE, ACCESS, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant that port.
- IDLE, both requests: grant the port not equal to the current grant. After reset, port 0 wins the first tie.
- On grant (same edge):
  - register the winner's addr, wr and wdata into mem_addr, mem_wr/mem_rd and mem_dout;
  - set grant;
  - lat_cnt=MEM_LAT-1;
  - go to ACCESS.
- ACCESS:
  - exactly one of mem_rd/mem_wr is high; mem_addr and mem_dout are stable for exactly MEM_LAT cycles;
  - lat_cnt decrements each cycle;
  - at lat_cnt==0, a read samples mem_din into the granted rdata register;
  - at lat_cnt==0, deassert strobes and go to DONE.
- DONE: the granted port's ack is high for exactly one cycle, then IDLE.
  - r*_rdata changes only on the granted port's read completion and holds until that port's next read completion.
  - Writes leave rdata unchanged.
- Latency: req sampled high in IDLE at edge N. Strobes are high for cycles N+1..N+MEM_LAT. Ack is high in cycle N+MEM_LAT+1. The earliest next grant is at the edge ending the first IDLE cycle after DONE.
- Requester rules:
  - req, wr, addr and wdata must be stable from assertion until ack.
  - req must be low in the cycle after ack. If it is still high, it is treated as a new request.
- A request dropped before ack is a protocol violation. Defined response: the access completes normally and ack still pulses.
- The ungranted port's request is ignored until IDLE and is never lost while held.
- busy=1 in ACCESS and DONE.
- mem_rd and mem_wr are never high simultaneously.

Test Plan:
- Port 0 single read, MEM_LAT=2, r0_addr=0x123, mem_din=0xBEEF → mem_rd high for 2 cycles with mem_addr=0x123. r0_ack pulses 3 cycles after the req sample edge; r0_rdata=0xBEEF; r1_ack stays 0.
- Port 1 write of r1_addr=0x0FF, r1_wdata=0x1234 → mem_wr high for 2 cycles with mem_dout=0x1234 and mem_rd=0. r1_ack pulses once; r1_rdata unchanged at 0x0000.
- Both requests held high continuously after reset, each dropping req for one cycle after its ack and then reasserting → grant order 0,1,0,1. No overlap of strobes; each ack is exactly one cycle.
- clr=0 in the second ACCESS cycle of a port 0 read → strobes 0 at the next edge, state IDLE, no r0_ack, r0_rdata=0. After clr returns to 1, a fresh port 0 read completes normally.
- MEM_LAT=1 build, port 1 read of 0xFFF with mem_din=0x0001 → mem_rd high for 1 cycle; r1_ack 2 cycles after the sample edge; r1_rdata=0x0001.
- Port 0 drops req in ACCESS → the access completes and r0_ack still pulses. A simultaneous r1_req is granted only after IDLE.
